alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 44 ++++
 rtl/alu_arbiter_if.sv | 58 +++++
 rtl/alu_arbiter_alu.sv | 59 +++++
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// ============================================================================
// Module      : alu_arbiter_pkg
// Description : Shared ALU op codes, flag bundle and arbiter FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package alu_arbiter_pkg;

    // RV32I OP funct3 encodings
    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_SLL  = 3'b001;
    localparam logic [2:0] c_F3_SLT  = 3'b010;
    localparam logic [2:0] c_F3_SLTU = 3'b011;
    localparam logic [2:0] c_F3_XOR  = 3'b100;
    localparam logic [2:0] c_F3_SRL  = 3'b101;
    localparam logic [2:0] c_F3_OR   = 3'b110;
    localparam logic [2:0] c_F3_AND  = 3'b111;

    // funct7 bit selecting sub / sra
    localparam int c_FUNCT7_ALT = 5;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_EXEC = c_ST_EXEC,
        ST_RESP = c_ST_RESP
    } state_t;

    typedef struct packed {
        logic eq;
        logic less;
        logic ge;
        logic less_u;
        logic ge_u;
    } alu_flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module      : alu_arbiter_if
// Description : Two-requester ALU request bus plus response channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface alu_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [2:0]      req0_funct3;
    logic [6:0]      req0_funct7;

    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [2:0]      req1_funct3;
    logic [6:0]      req1_funct7;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [XLEN-1:0] rsp_res;
    logic            rsp_eq;
    logic            rsp_less;
    logic            rsp_ge;
    logic            rsp_less_u;
    logic            rsp_ge_u;

    modport master (
        output req0_valid, req0_a, req0_b, req0_funct3, req0_funct7,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_funct3, req1_funct7,
        input  req1_ready,
        output rsp_ready,
        input  rsp_valid, rsp_id, rsp_res,
        input  rsp_eq, rsp_less, rsp_ge, rsp_less_u, rsp_ge_u
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_funct3, req0_funct7,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_funct3, req1_funct7,
        output req1_ready,
        input  rsp_ready,
        output rsp_valid, rsp_id, rsp_res,
        output rsp_eq, rsp_less, rsp_ge, rsp_less_u, rsp_ge_u
    );

endinterface

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
// ============================================================================
// Module      : alu
// Description : Combinational RV32I OP-class ALU with signed/unsigned flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [XLEN-1:0] i_a,
    input  wire logic [XLEN-1:0] i_b,
    input  wire logic [2:0]      i_funct3,
    input  wire logic [6:0]      i_funct7,
    output logic      [XLEN-1:0] o_res,
    output alu_flags_t           o_flags
);

    logic       w_alt;
    logic [4:0] w_shamt;
    logic       w_lt_s;
    logic       w_lt_u;
    logic       w_unused_funct7;

    assign w_alt   = i_funct7[c_FUNCT7_ALT];
    assign w_shamt = i_b[4:0];
    assign w_lt_s  = $signed(i_a) < $signed(i_b);
    assign w_lt_u  = i_a < i_b;

    // Only the alt bit of funct7 selects behaviour.
    assign w_unused_funct7 = ^{i_funct7[6], i_funct7[4:0]};

    always_comb begin
        o_res = '0;
        case (i_funct3)
            c_F3_ADD:  o_res = w_alt ? (i_a - i_b) : (i_a + i_b);
            c_F3_SLL:  o_res = i_a << w_shamt;
            c_F3_SLT:  o_res = {{(XLEN-1){1'b0}}, w_lt_s};
            c_F3_SLTU: o_res = {{(XLEN-1){1'b0}}, w_lt_u};
            c_F3_XOR:  o_res = i_a ^ i_b;
            c_F3_SRL:  o_res = w_alt ? $unsigned($signed(i_a) >>> w_shamt) : (i_a >> w_shamt);
            c_F3_OR:   o_res = i_a | i_b;
            c_F3_AND:  o_res = i_a & i_b;
            default:   o_res = '0;
        endcase
    end

    assign o_flags.eq     = (i_a == i_b);
    assign o_flags.less   = w_lt_s;
    assign o_flags.ge     = ~w_lt_s;
    assign o_flags.less_u = w_lt_u;
    assign o_flags.ge_u   = ~w_lt_u;

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter sharing one ALU between two requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    alu_arbiter_if.slave  bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_grant;     // 1: req1 was granted most recently
    logic            w_winner;
    logic            w_ready0;
    logic            w_ready1;

    logic [XLEN-1:0] r_op_a;
    logic [XLEN-1:0] r_op_b;
    logic [2:0]      r_op_funct3;
    logic [6:0]      r_op_funct7;
    logic            r_op_id;

    logic [XLEN-1:0] r_rsp_res;
    alu_flags_t      r_rsp_flags;
    logic            r_rsp_id;

    logic [XLEN-1:0] w_alu_res;
    alu_flags_t      w_alu_flags;

    alu #(
        .XLEN (XLEN)
    ) u_alu (
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .i_funct3 (r_op_funct3),
        .i_funct7 (r_op_funct7),
        .o_res    (w_alu_res),
        .o_flags  (w_alu_flags)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_winner    = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_winner = ~r_last_grant;
        end
        case (r_state)
            ST_IDLE: begin
                w_ready0 = ~rst & bus.req0_valid & ~w_winner;
                w_ready1 = ~rst & bus.req1_valid &  w_winner;
                if (w_ready0 || w_ready1) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_funct3  <= '0;
            r_op_funct7  <= '0;
            r_op_id      <= 1'b0;
            r_rsp_res    <= '0;
            r_rsp_flags  <= '0;
            r_rsp_id     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ready0 || w_ready1) begin
                r_last_grant <= w_ready1;
                r_op_id      <= w_ready1;
                if (w_ready1) begin
                    r_op_a      <= bus.req1_a;
                    r_op_b      <= bus.req1_b;
                    r_op_funct3 <= bus.req1_funct3;
                    r_op_funct7 <= bus.req1_funct7;
                end else begin
                    r_op_a      <= bus.req0_a;
                    r_op_b      <= bus.req0_b;
                    r_op_funct3 <= bus.req0_funct3;
                    r_op_funct7 <= bus.req0_funct7;
                end
            end
            if (r_state == ST_EXEC) begin
                r_rsp_res   <= w_alu_res;
                r_rsp_flags <= w_alu_flags;
                r_rsp_id    <= r_op_id;
            end
        end
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.rsp_valid  = (r_state == ST_RESP);
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_res    = r_rsp_res;
    assign bus.rsp_eq     = r_rsp_flags.eq;
    assign bus.rsp_less   = r_rsp_flags.less;
    assign bus.rsp_ge     = r_rsp_flags.ge;
    assign bus.rsp_less_u = r_rsp_flags.less_u;
    assign bus.rsp_ge_u   = r_rsp_flags.ge_u;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed, self-checking bench for alu_arbiter with a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.XLEN(32)) bus ();

    alu_arbiter #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        eq;
        logic        less;
        logic        ge;
        logic        less_u;
        logic        ge_u;
        logic        id;
    } exp_t;

    typedef struct {
        exp_t r;
        int   due;
    } pend_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: 64-bit arithmetic, results truncated to 32 bits.
    function automatic exp_t ref_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] f3, input logic [6:0] f7);
        exp_t        e;
        longint      sa;
        longint      sb;
        int unsigned sh;
        sa = $signed(a);
        sb = $signed(b);
        sh = b[4:0];
        case (f3)
            3'd0:    e.res = f7[5] ? a - b : a + b;
            3'd1:    e.res = a << sh;
            3'd2:    e.res = (sa < sb) ? 32'd1 : 32'd0;
            3'd3:    e.res = (a < b) ? 32'd1 : 32'd0;
            3'd4:    e.res = a ^ b;
            3'd5:    e.res = f7[5] ? 32'(sa >>> sh) : (a >> sh);
            3'd6:    e.res = a | b;
            default: e.res = a & b;
        endcase
        e.eq     = (a == b);
        e.less   = (sa < sb);
        e.ge     = (sa >= sb);
        e.less_u = (a < b);
        e.ge_u   = (a >= b);
        e.id     = id;
        return e;
    endfunction

    function automatic exp_t dut_rsp();
        exp_t d;
        d.res    = bus.rsp_res;
        d.eq     = bus.rsp_eq;
        d.less   = bus.rsp_less;
        d.ge     = bus.rsp_ge;
        d.less_u = bus.rsp_less_u;
        d.ge_u   = bus.rsp_ge_u;
        d.id     = bus.rsp_id;
        return d;
    endfunction

    // ---------------- cycle model + compare process ----------------
    pend_t q[$];
    exp_t  m_shown;
    logic  m_last  = 1'b1;
    bit    m_known = 1'b0;
    int    cyc     = 0;

    always @(negedge clk) begin
        bit e0, e1, ev, free;
        cyc++;
        if (m_known) begin
            ev = (q.size() > 0) && (cyc >= q[0].due);
            if (ev) m_shown = q[0].r;
            free = (q.size() == 0);
            e0 = 1'b0;
            e1 = 1'b0;
            if (free && !rst) begin
                if (bus.req0_valid && bus.req1_valid) begin
                    e0 = m_last;
                    e1 = !m_last;
                end else begin
                    e0 = bus.req0_valid;
                    e1 = bus.req1_valid;
                end
            end
            chk("cmp_req0_ready", bus.req0_ready, e0);
            chk("cmp_req1_ready", bus.req1_ready, e1);
            chk("cmp_rsp_valid", bus.rsp_valid, ev);
            chk("cmp_rsp_fields", dut_rsp(), m_shown);
            if (rst) begin
                q.delete();
                m_last  = 1'b1;
                m_shown = '0;
            end else begin
                if (ev && bus.rsp_ready) void'(q.pop_front());
                if (e0) q.push_back('{ref_op(1'b0, bus.req0_a, bus.req0_b, bus.req0_funct3, bus.req0_funct7), cyc + 2});
                if (e1) q.push_back('{ref_op(1'b1, bus.req1_a, bus.req1_b, bus.req1_funct3, bus.req1_funct7), cyc + 2});
                if (e0 || e1) m_last = e1;
            end
        end else if (rst) begin
            m_known = 1'b1;
            q.delete();
            m_last  = 1'b1;
            m_shown = '0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f3, input logic [6:0] f7);
        if (id == 1'b0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
            bus.req0_funct3 = f3; bus.req0_funct7 = f7;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
            bus.req1_funct3 = f3; bus.req1_funct7 = f7;
        end
    endtask

    // Issues one op and returns at the negedge of the first rsp_valid cycle.
    task automatic do_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [6:0] f7,
                         output exp_t r, output int lat);
        bit got;
        int n;
        r   = '0;
        got = 1'b0;
        n   = 0;
        set_req(id, 1'b1, a, b, f3, f7);
        while (!got && n < 10) begin
            @(negedge clk);
            if ((id == 1'b0) ? bus.req0_ready : bus.req1_ready) got = 1'b1;
            else begin tick(); n++; end
        end
        if (!got) chk("grant_timeout", 0, 1);
        tick();
        if (id == 1'b0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            if (bus.rsp_valid) got = 1'b1;
            else begin tick(); lat++; end
        end
        if (!got) chk("rsp_timeout", 0, 1);
        r = dut_rsp();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        exp_t  r;
        exp_t  held;
        int    lat;
        int    g[$];
        int    ids[$];

        set_req(1'b0, 1'b1, 32'd0, 32'd0, 3'd0, 7'd0);
        set_req(1'b1, 1'b1, 32'd0, 32'd0, 3'd0, 7'd0);
        bus.rsp_ready = 1'b1;
        rst = 1'b1;

        // Reset state; readies stay low even with both valids high.
        @(negedge clk);
        @(negedge clk);
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_req1_ready", bus.req1_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_fields", dut_rsp(), 0);
        tick();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // req0 alone: 20 + 7
        do_op(1'b0, 32'd20, 32'd7, 3'b000, 7'd0, r, lat);
        chk("add_latency", lat, 2);
        chk("add_res", r.res, 27);
        chk("add_id", r.id, 0);
        chk("add_ge", r.ge, 1);
        tick();

        // req1 alone: -100 >>> 4
        do_op(1'b1, -32'sd100, 32'd4, 3'b101, 7'b0100000, r, lat);
        chk("sra_res", r.res, 32'hFFFF_FFF9);
        chk("sra_less", r.less, 1);
        chk("sra_ge_u", r.ge_u, 1);
        chk("sra_id", r.id, 1);
        tick();

        // slt vs sltu on operands of opposite sign
        do_op(1'b0, 32'd10000000, -32'sd10000000, 3'b010, 7'd0, r, lat);
        chk("slt_res", r.res, 0);
        chk("slt_less", r.less, 0);
        tick();
        do_op(1'b0, 32'd10000000, -32'sd10000000, 3'b011, 7'd0, r, lat);
        chk("sltu_res", r.res, 1);
        chk("sltu_less_u", r.less_u, 1);
        tick();

        // Response held while the consumer stalls; inputs churn meanwhile.
        bus.rsp_ready = 1'b0;
        do_op(1'b0, 32'd5, 32'd6, 3'b000, 7'd0, held, lat);
        chk("hold_first_res", held.res, 11);
        for (int i = 0; i < 5; i++) begin
            tick();
            set_req(1'b0, 1'b1, $urandom, $urandom, 3'($urandom_range(0, 7)), 7'($urandom));
            @(negedge clk);
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_rsp_fields", dut_rsp(), held);
            chk("hold_no_ready", bus.req0_ready, 0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_no_ready", bus.req0_ready, 0);
        tick();
        @(negedge clk);
        chk("idle_after_release", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        repeat (3) tick();

        // Fresh reset, then both valid continuously for four ops.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1'b0, 1'b1, 32'd1, 32'd2, 3'b000, 7'd0);
        set_req(1'b1, 1'b1, 32'd100, 32'd30, 3'b000, 7'b0100000);
        for (int n = 0; n < 40 && ids.size() < 4; n++) begin
            @(negedge clk);
            if (bus.req0_ready) g.push_back(0);
            if (bus.req1_ready) g.push_back(1);
            if (bus.rsp_valid && bus.rsp_ready) ids.push_back(int'(bus.rsp_id));
            tick();
            if (g.size() >= 4) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end
        chk("rr_grant_count", g.size(), 4);
        chk("rr_rsp_count", ids.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("rr_grant_order", (i < g.size()) ? g[i] : 9, i % 2);
            chk("rr_rsp_id", (i < ids.size()) ? ids[i] : 9, i % 2);
        end
        repeat (2) tick();

        // Reset during EXEC drops the op; req0 then wins the next tie.
        set_req(1'b0, 1'b1, 32'd3, 32'd4, 3'b000, 7'd0);
        @(negedge clk);
        chk("drop_grant", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("drop_exec_no_rsp", bus.rsp_valid, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drop_no_rsp", bus.rsp_valid, 0);
            tick();
        end
        set_req(1'b0, 1'b1, 32'd8, 32'd8, 3'b100, 7'd0);
        set_req(1'b1, 1'b1, 32'd9, 32'd1, 3'b001, 7'd0);
        @(negedge clk);
        chk("post_rst_tie_req0", bus.req0_ready, 1);
        chk("post_rst_tie_req1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
